// File: rtl/serv_rf_arb_if.sv
// Bundle of the core/debug request ports, the register-file RAM handshake and
// the arbiter status outputs. The arbiter connects through 'slave'; the
// requesters, the RAM and the status consumers connect through 'master'.
interface serv_rf_arb_if;
    logic       i_c_req;
    logic       i_c_wen;
    logic       o_c_gnt;
    logic       i_d_req;
    logic       i_d_wen;
    logic       o_d_gnt;
    logic       o_rreq;
    logic       i_rgnt;
    logic       o_wreq;
    logic       o_sel;
    logic [4:0] o_cnt;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    modport slave (
        input  i_c_req,
        input  i_c_wen,
        output o_c_gnt,
        input  i_d_req,
        input  i_d_wen,
        output o_d_gnt,
        output o_rreq,
        input  i_rgnt,
        output o_wreq,
        output o_sel,
        output o_cnt,
        output o_busy,
        output o_done,
        output o_err
    );

    modport master (
        output i_c_req,
        output i_c_wen,
        input  o_c_gnt,
        output i_d_req,
        output i_d_wen,
        input  o_d_gnt,
        input  o_rreq,
        output i_rgnt,
        input  o_wreq,
        input  o_sel,
        input  o_cnt,
        input  o_busy,
        input  o_done,
        input  o_err
    );
endinterface

// File: rtl/serv_rf_arb.sv
// Register-file access arbiter: shares one serial register-file window between
// the core and the debug/init engine, round-robin on ties, with a bounded wait
// for the RAM read grant.
//
// state | meaning
// IDLE  | no access; arbitrate pending requests, latch the winner into o_sel
// RREQ  | o_rreq high for one cycle, timeout counter loaded
// WAIT  | waiting for i_rgnt; owner's gnt follows it, or o_err after TMO cycles
// XFER  | serial window, o_cnt runs 0..31
// WB    | o_wreq and o_done high for one cycle, last-served pointer updated
module serv_rf_arb #(
    parameter int TMO = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    serv_rf_arb_if.slave bus
);

    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RREQ = 3'd1,
        WAIT = 3'd2,
        XFER = 3'd3,
        WB   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Owner of the current access (0 core, 1 debug) and the owner served last.
    logic sel;
    logic sel_nxt;
    logic last;
    logic last_nxt;

    // Writeback flag captured together with the RAM read grant.
    logic wen;
    logic wen_nxt;

    logic [4:0] cnt;
    logic [4:0] cnt_nxt;

    // Grant timeout down-counter; expiry is its terminal count of zero.
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmo_nxt;

    // Output pulses are computed one cycle ahead and registered.
    logic c_gnt_q, c_gnt_nxt;
    logic d_gnt_q, d_gnt_nxt;
    logic rreq_q,  rreq_nxt;
    logic wreq_q,  wreq_nxt;
    logic done_q,  done_nxt;
    logic err_q,   err_nxt;

    logic req_any;
    logic req_both;

    assign req_any  = bus.i_c_req | bus.i_d_req;
    assign req_both = bus.i_c_req & bus.i_d_req;

    // State register; reset abandons any access in flight without a pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, arbitration, counters and the pulses for the next cycle.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        wen_nxt   = wen;
        cnt_nxt   = 5'd0;
        tmo_nxt   = tmo;
        c_gnt_nxt = 1'b0;
        d_gnt_nxt = 1'b0;
        rreq_nxt  = 1'b0;
        wreq_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    // A tie goes to whoever was not served last.
                    sel_nxt   = req_both ? ~last : bus.i_d_req;
                    rreq_nxt  = 1'b1;
                    state_nxt = RREQ;
                end
            end

            RREQ: begin
                tmo_nxt   = TMO_LOAD;
                state_nxt = WAIT;
            end

            WAIT: begin
                if (bus.i_rgnt) begin
                    c_gnt_nxt = ~sel;
                    d_gnt_nxt = sel;
                    wen_nxt   = sel ? bus.i_d_wen : bus.i_c_wen;
                    state_nxt = XFER;
                end else if (tmo == '0) begin
                    // Aborted accesses do not count as served.
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo - TW'(1);
                end
            end

            XFER: begin
                if (cnt == 5'd31) begin
                    done_nxt = 1'b1;
                    if (wen) begin
                        wreq_nxt  = 1'b1;
                        state_nxt = WB;
                    end else begin
                        last_nxt  = sel;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end

            WB: begin
                last_nxt  = sel;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel     <= 1'b0;
            last    <= 1'b1;
            wen     <= 1'b0;
            cnt     <= 5'd0;
            tmo     <= '0;
            c_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel     <= sel_nxt;
            last    <= last_nxt;
            wen     <= wen_nxt;
            cnt     <= cnt_nxt;
            tmo     <= tmo_nxt;
            c_gnt_q <= c_gnt_nxt;
            d_gnt_q <= d_gnt_nxt;
            rreq_q  <= rreq_nxt;
            wreq_q  <= wreq_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.o_c_gnt = c_gnt_q;
    assign bus.o_d_gnt = d_gnt_q;
    assign bus.o_rreq  = rreq_q;
    assign bus.o_wreq  = wreq_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
    assign bus.o_sel   = sel;
    assign bus.o_cnt   = cnt;
    assign bus.o_busy  = (state != IDLE);

endmodule

// File: tb/tb_serv_rf_arb.sv
// Bench for serv_rf_arb: directed request patterns, a responding RAM model,
// a cycle monitor and a scoreboard of expected access outcomes.
module tb_serv_rf_arb;

    localparam int TMO = 4;

    typedef struct packed {
        logic own;
        logic wen;
        logic err;
    } sb_t;

    logic clk;
    logic rst;
    serv_rf_arb_if bus();

    serv_rf_arb #(.TMO(TMO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int  n_vec  = 0;
    int  n_err  = 0;
    int  n_compl = 0;
    int  cyc    = 0;
    int  rg_delay = 2;
    bit  rg_spur  = 1'b0;
    sb_t sb[$];

    // monitor state
    bit xf_act    = 1'b0;
    bit post      = 1'b0;
    bit own       = 1'b0;
    bit prev_busy = 1'b0;
    int exp_cnt   = 0;
    int rreq_cyc  = 0;
    int exp_dly   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit cond_met(input int kind, input int val);
        case (kind)
            0:       return bus.o_c_gnt | bus.o_d_gnt;
            1:       return bus.o_cnt == 5'(val);
            default: return n_compl >= val;
        endcase
    endfunction

    task automatic wait_cond(input int kind, input int val, input int lim, input string tag);
        int n = 0;
        while (!cond_met(kind, val) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(cond_met(kind, val)), 1);
    endtask

    // RAM model: answers o_rreq with a one-cycle i_rgnt rg_delay cycles later
    // (never when rg_delay is 0), optionally followed by a stray grant mid-window.
    initial begin
        bus.i_rgnt = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_rreq && rg_delay > 0) begin
                repeat (rg_delay) @(negedge clk);
                bus.i_rgnt = 1'b1;
                @(negedge clk);
                bus.i_rgnt = 1'b0;
                if (rg_spur) begin
                    repeat (12) @(negedge clk);
                    bus.i_rgnt = 1'b1;
                    @(negedge clk);
                    bus.i_rgnt = 1'b0;
                end
            end
        end
    end

    // Cycle monitor: timing of pulses, counter sequence, owner stability and
    // scoreboard pops on every completed or aborted access.
    initial begin
        int  npl;
        sb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                xf_act    = 1'b0;
                post      = 1'b0;
                prev_busy = 1'b0;
                sb.delete();
                continue;
            end

            npl = int'(bus.o_c_gnt) + int'(bus.o_d_gnt) + int'(bus.o_rreq) + int'(bus.o_wreq)
                + int'(bus.o_done && !bus.o_wreq) + int'(bus.o_err);
            if (npl != 0) check_val("pulse_excl", 32'(npl), 1);

            if (post) begin
                check_val("done_lat", 32'(bus.o_done), 1);
                check_val("cnt_wrap", 32'(bus.o_cnt), 0);
                post = 1'b0;
            end

            if (bus.o_rreq) begin
                check_val("idle_gap", 32'(prev_busy), 0);
                check_val("cnt_idle", 32'(bus.o_cnt), 0);
                rreq_cyc = cyc;
                exp_dly  = rg_delay;
            end

            if (bus.o_c_gnt || bus.o_d_gnt) begin
                check_val("gnt_dup", 32'(xf_act), 0);
                check_val("gnt_lat", 32'(cyc), 32'(rreq_cyc + exp_dly + 1));
                check_val("gnt_sel", 32'(bus.o_sel), 32'(bus.o_d_gnt));
                xf_act  = 1'b1;
                exp_cnt = 0;
                own     = bus.o_d_gnt;
            end

            if (xf_act) begin
                check_val("cnt_seq", 32'(bus.o_cnt), 32'(exp_cnt));
                check_val("sel_hold", 32'(bus.o_sel), 32'(own));
                if (exp_cnt == 31) begin
                    xf_act = 1'b0;
                    post   = 1'b1;
                end else begin
                    exp_cnt++;
                end
            end

            if (bus.o_done || bus.o_err) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_owner", 32'(bus.o_sel), 32'(e.own));
                    check_val("sb_wb", 32'(bus.o_wreq), 32'(e.wen));
                    check_val("sb_err", 32'(bus.o_err), 32'(e.err));
                end
                if (bus.o_err) begin
                    check_val("err_lat", 32'(cyc), 32'(rreq_cyc + 1 + TMO));
                    check_val("err_idle", 32'(bus.o_busy), 0);
                end else begin
                    check_val("done_busy", 32'(bus.o_busy), 32'(bus.o_wreq));
                end
                n_compl++;
            end

            prev_busy = bus.o_busy;
        end
    end

    // Directed stimulus; each access pushes its expected outcome.
    initial begin
        int tgt;
        rst         = 1'b1;
        bus.i_c_req = 1'b0;
        bus.i_c_wen = 1'b0;
        bus.i_d_req = 1'b0;
        bus.i_d_wen = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_busy", 32'(bus.o_busy), 0);
        check_val("rst_cnt", 32'(bus.o_cnt), 0);
        check_val("rst_sel", 32'(bus.o_sel), 0);
        check_val("rst_gnt", 32'({bus.o_c_gnt, bus.o_d_gnt}), 0);
        check_val("rst_rw", 32'({bus.o_rreq, bus.o_wreq}), 0);
        check_val("rst_de", 32'({bus.o_done, bus.o_err}), 0);

        // Both requesting from reset: core, debug, core, debug.
        bus.i_c_wen = 1'b1;
        bus.i_d_wen = 1'b0;
        bus.i_c_req = 1'b1;
        bus.i_d_req = 1'b1;
        rst = 1'b0;
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        sb.push_back('{own: 1'b1, wen: 1'b0, err: 1'b0});
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        sb.push_back('{own: 1'b1, wen: 1'b0, err: 1'b0});
        tgt = n_compl + 4;
        wait_cond(2, tgt, 400, "rr_wait");
        bus.i_c_req = 1'b0;
        bus.i_d_req = 1'b0;
        repeat (3) @(negedge clk);

        // Core alone with writeback; stray i_rgnt during the window.
        rg_delay = 2;
        rg_spur  = 1'b1;
        bus.i_c_req = 1'b1;
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        tgt = n_compl + 1;
        wait_cond(0, 0, 50, "core_gnt");
        bus.i_c_req = 1'b0;
        wait_cond(2, tgt, 100, "core_done");
        rg_spur = 1'b0;
        repeat (2) @(negedge clk);

        // Debug alone, no writeback.
        rg_delay = 1;
        bus.i_d_wen = 1'b0;
        bus.i_d_req = 1'b1;
        sb.push_back('{own: 1'b1, wen: 1'b0, err: 1'b0});
        tgt = n_compl + 1;
        wait_cond(0, 0, 50, "dbg_gnt");
        bus.i_d_req = 1'b0;
        wait_cond(2, tgt, 100, "dbg_done");
        repeat (2) @(negedge clk);

        // Grant never arrives: timeout, then the same tie goes to core again.
        rg_delay = 0;
        bus.i_c_req = 1'b1;
        bus.i_d_req = 1'b1;
        sb.push_back('{own: 1'b0, wen: 1'b0, err: 1'b1});
        tgt = n_compl + 1;
        wait_cond(2, tgt, 50, "tmo_err");
        rg_delay = 2;
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        tgt = n_compl + 1;
        wait_cond(0, 0, 50, "tmo_regnt");
        check_val("tmo_owner", 32'(bus.o_c_gnt), 1);
        bus.i_c_req = 1'b0;
        bus.i_d_req = 1'b0;
        wait_cond(2, tgt, 100, "tmo_done");
        repeat (2) @(negedge clk);

        // Reset in the middle of the window.
        bus.i_c_req = 1'b1;
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        wait_cond(0, 0, 50, "mid_gnt");
        bus.i_c_req = 1'b0;
        wait_cond(1, 10, 40, "mid_cnt10");
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_busy", 32'(bus.o_busy), 0);
        check_val("mid_cnt", 32'(bus.o_cnt), 0);
        check_val("mid_de", 32'({bus.o_done, bus.o_err}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_c_req = 1'b1;
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        tgt = n_compl + 1;
        wait_cond(0, 0, 50, "post_gnt");
        bus.i_c_req = 1'b0;
        wait_cond(2, tgt, 100, "post_done");
        repeat (2) @(negedge clk);

        // Request dropped mid-window still completes with writeback.
        bus.i_c_req = 1'b1;
        sb.push_back('{own: 1'b0, wen: 1'b1, err: 1'b0});
        tgt = n_compl + 1;
        wait_cond(1, 5, 60, "drop_cnt5");
        bus.i_c_req = 1'b0;
        wait_cond(2, tgt, 100, "drop_done");
        repeat (4) @(negedge clk);

        check_val("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
